// File: rtl/key_ram_writer_if.sv
//==============================================================================
// Module  : key_ram_writer_if
// Brief   : Write-port bundle from the keyboard writer into the shared RAM.
//           The master drives a fixed byte address plus a level-type write
//           enable and data word; the slave (RAM) bypasses the data while
//           wen is high.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface key_ram_writer_if;
  logic [12:0] key_ram_addr;
  logic [31:0] key_ram_wdata;
  logic        key_ram_wen;

  modport master (output key_ram_addr, output key_ram_wdata, output key_ram_wen);
  modport slave  (input  key_ram_addr, input  key_ram_wdata, input  key_ram_wen);
endinterface

`default_nettype wire

// File: rtl/key_ram_writer.sv
//==============================================================================
// Module  : key_ram_writer
// Brief   : PS/2 keyboard receiver. Synchronises the PS/2 clock/data lines,
//           deframes 11-bit frames (start, 8 data LSB first, odd parity,
//           stop), decodes scan-code set 2 make/break sequences and presents
//           the ASCII code of the currently held key on a RAM write port.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module key_ram_writer #(
  parameter logic [12:0] SCAN_ASCII_ADDR = 13'h0310,
  parameter int unsigned TIMEOUT_CYCLES  = 50000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  key_ram_writer_if.master key_ram
);

  // Timeout counter must be able to hold TIMEOUT_CYCLES-1.
  localparam int unsigned         c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0]   c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Synchroniser and edge detector
  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;
  logic w_fall;

  // Frame receiver
  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_rx_sr;
  logic               r_parity;
  logic [c_TO_W-1:0]  r_to_cnt;
  logic               w_timeout;
  logic               w_byte_ok;
  logic               r_byte_valid;

  // Decoder
  logic               r_ext;
  logic               r_brk;
  logic               r_shift_key;
  logic [7:0]         r_held_code;
  logic               r_wen;
  logic [31:0]        r_wdata;
  logic [7:0]         w_letter;
  logic [7:0]         w_ascii;
  logic               w_mapped;
  logic               w_is_shift;

  // Lowercase ASCII for set-2 letter codes, 8'h00 if the code is not a letter.
  function automatic logic [7:0] letter_of(input logic [7:0] code);
    logic [7:0] r;
    r = 8'h00;
    case (code)
      8'h1C: r = 8'h61; 8'h32: r = 8'h62; 8'h21: r = 8'h63; 8'h23: r = 8'h64;
      8'h24: r = 8'h65; 8'h2B: r = 8'h66; 8'h34: r = 8'h67; 8'h33: r = 8'h68;
      8'h43: r = 8'h69; 8'h3B: r = 8'h6A; 8'h42: r = 8'h6B; 8'h4B: r = 8'h6C;
      8'h3A: r = 8'h6D; 8'h31: r = 8'h6E; 8'h44: r = 8'h6F; 8'h4D: r = 8'h70;
      8'h15: r = 8'h71; 8'h2D: r = 8'h72; 8'h1B: r = 8'h73; 8'h2C: r = 8'h74;
      8'h3C: r = 8'h75; 8'h2A: r = 8'h76; 8'h1D: r = 8'h77; 8'h22: r = 8'h78;
      8'h35: r = 8'h79; 8'h1A: r = 8'h7A;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // ASCII for digits and the few control/space keys, 8'h00 if unmapped.
  function automatic logic [7:0] other_of(input logic [7:0] code);
    logic [7:0] r;
    r = 8'h00;
    case (code)
      8'h45: r = 8'h30; 8'h16: r = 8'h31; 8'h1E: r = 8'h32; 8'h26: r = 8'h33;
      8'h25: r = 8'h34; 8'h2E: r = 8'h35; 8'h36: r = 8'h36; 8'h3D: r = 8'h37;
      8'h3E: r = 8'h38; 8'h46: r = 8'h39;
      8'h29: r = 8'h20; 8'h5A: r = 8'h0D; 8'h66: r = 8'h08;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Two-flop synchronisers plus one history flop for clock edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;

  // Receiver state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Receiver next state; a stalled frame is dropped after the idle timeout,
  // and a falling edge always wins over the timeout in the same cycle.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    w_byte_ok = 1'b0;
    if (r_state != S_IDLE && !w_fall && r_to_cnt == c_TO_LAST) begin
      w_timeout = 1'b1;
      w_next    = S_IDLE;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!r_dat_s2) w_next = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_next = S_PARITY;
        S_PARITY: w_next = S_STOP;
        S_STOP: begin
          w_next    = S_IDLE;
          // Stop must be 1 and data+parity must carry an odd number of ones.
          w_byte_ok = r_dat_s2 & (^{r_rx_sr, r_parity});
        end
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Receiver datapath: bit shifting, parity capture, timeout count, byte strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt    <= 3'd0;
      r_rx_sr      <= 8'h00;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_byte_valid <= w_byte_ok;

      if (r_state == S_IDLE || w_fall || w_timeout) r_to_cnt <= '0;
      else                                          r_to_cnt <= r_to_cnt + c_TO_W'(1);

      if (w_fall) begin
        case (r_state)
          S_IDLE:   r_bit_cnt <= 3'd0;
          S_DATA: begin
            r_rx_sr   <= {r_dat_s2, r_rx_sr[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: r_parity <= r_dat_s2;
          default:  ;
        endcase
      end
    end
  end

  assign w_is_shift = (r_rx_sr == 8'h12) || (r_rx_sr == 8'h59);
  assign w_letter   = letter_of(r_rx_sr);
  assign w_ascii    = (w_letter != 8'h00)
                    ? (r_shift_key ? (w_letter - 8'h20) : w_letter)
                    : other_of(r_rx_sr);
  assign w_mapped   = (w_ascii != 8'h00);

  // Scan-code decoder; the received byte stays stable in r_rx_sr while
  // r_byte_valid is high because the next frame is hundreds of cycles away.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_shift_key <= 1'b0;
      r_held_code <= 8'h00;
      r_wen       <= 1'b0;
      r_wdata     <= 32'h0;
    end else if (r_byte_valid) begin
      if (r_rx_sr == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_rx_sr == 8'hF0) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (!r_ext) begin
          if (w_is_shift) begin
            r_shift_key <= ~r_brk;
          end else if (w_mapped) begin
            if (!r_brk) begin
              // Typematic repeats of the held key leave the outputs alone.
              if (r_held_code != r_rx_sr) begin
                r_held_code <= r_rx_sr;
                r_wen       <= 1'b1;
                r_wdata     <= {24'h0, w_ascii};
              end
            end else if (r_held_code == r_rx_sr) begin
              r_held_code <= 8'h00;
              r_wen       <= 1'b0;
              r_wdata     <= 32'h0;
            end
          end
        end
      end
    end
  end

  assign key_ram.key_ram_addr  = SCAN_ASCII_ADDR;
  assign key_ram.key_ram_wen   = r_wen;
  assign key_ram.key_ram_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_key_ram_writer.sv
//==============================================================================
// Module  : tb_key_ram_writer
// Brief   : Directed bench for key_ram_writer: drives PS/2 frames bit by bit
//           and compares the RAM write port against hand-computed values.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_key_ram_writer;

  localparam int HALF = 30;     // PS/2 half bit period in system clocks
  localparam int TO   = 1000;   // shortened idle timeout for simulation

  logic clock;
  logic reset_n;
  logic ps2_clk;
  logic ps2_data;
  int   n_total;
  int   n_bad;

  key_ram_writer_if kif ();

  key_ram_writer #(
    .SCAN_ASCII_ADDR (13'h0310),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_ram  (kif)
  );

  // 100 MHz-style bench clock; only relative cycle counts matter.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    idle(HALF);
    ps2_clk = 1'b0;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  // Sends a frame up to and including the stop falling edge (left low).
  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ bad_par);
    ps2_data = stop;
    idle(HALF);
    ps2_clk = 1'b0;
  endtask

  task automatic finish_frame();
    idle(HALF);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    idle(100);
  endtask

  task automatic frame(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b1);
    finish_frame();
  endtask

  task automatic chk_out(input string tag, input logic wen, input logic [31:0] wdata);
    chk({tag, "_wen"},   {31'h0, kif.key_ram_wen}, {31'h0, wen});
    chk({tag, "_wdata"}, kif.key_ram_wdata,        wdata);
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;

    // Reset state
    idle(5);
    chk_out("reset", 1'b0, 32'h0);
    chk("reset_addr", {19'h0, kif.key_ram_addr}, 32'h0000_0310);
    reset_n = 1'b1;
    idle(20);

    // 1C: output appears exactly two cycles after the stop edge
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (3) @(posedge clock);
    #1 chk("lat_t1_wen", {31'h0, kif.key_ram_wen}, 32'h0);
    @(posedge clock);
    #1 chk_out("lat_t2", 1'b1, 32'h0000_0061);
    finish_frame();
    frame(8'hF0); frame(8'h1C);
    chk_out("brk_1c", 1'b0, 32'h0);

    // Shift + letter gives uppercase, release order as in normal typing
    frame(8'h12); frame(8'h1C);
    chk_out("shift_A", 1'b1, 32'h0000_0041);
    frame(8'hF0); frame(8'h1C);
    chk_out("shift_brk", 1'b0, 32'h0);
    frame(8'hF0); frame(8'h12);
    frame(8'h1C);
    chk_out("shift_clear", 1'b1, 32'h0000_0061);
    frame(8'hF0); frame(8'h1C);

    // Right shift with a letter, left shift with a digit
    frame(8'h59); frame(8'h4D);
    chk_out("rshift_P", 1'b1, 32'h0000_0050);
    frame(8'hF0); frame(8'h4D); frame(8'hF0); frame(8'h59);
    frame(8'h12); frame(8'h16);
    chk_out("shift_digit", 1'b1, 32'h0000_0031);
    frame(8'hF0); frame(8'h16); frame(8'hF0); frame(8'h12);
    chk_out("digit_brk", 1'b0, 32'h0);

    // Bad parity then bad stop bit: both frames dropped
    send_frame(8'h1C, 1'b1, 1'b1); finish_frame();
    chk_out("bad_par", 1'b0, 32'h0);
    send_frame(8'h1C, 1'b0, 1'b0); finish_frame();
    chk_out("bad_stop", 1'b0, 32'h0);

    // Partial frame abandoned by the idle timeout
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    idle(TO + 200);
    frame(8'h29);
    chk_out("timeout_space", 1'b1, 32'h0000_0020);
    frame(8'hF0); frame(8'h29);

    // New make replaces held key; stale break, extended codes, repeats ignored
    frame(8'h1C); frame(8'h32);
    chk_out("replace_b", 1'b1, 32'h0000_0062);
    frame(8'hF0); frame(8'h1C);
    chk_out("stale_brk", 1'b1, 32'h0000_0062);
    frame(8'hE0); frame(8'h75);
    chk_out("ext_make", 1'b1, 32'h0000_0062);
    frame(8'hE0); frame(8'hF0); frame(8'h75);
    chk_out("ext_brk", 1'b1, 32'h0000_0062);
    frame(8'h76);
    chk_out("unmapped", 1'b1, 32'h0000_0062);
    frame(8'h12); frame(8'h32);
    chk_out("typematic", 1'b1, 32'h0000_0062);
    frame(8'hF0); frame(8'h12);
    frame(8'hF0); frame(8'h32);
    chk_out("brk_b", 1'b0, 32'h0);

    // Enter and backspace
    frame(8'h5A);
    chk_out("enter", 1'b1, 32'h0000_000D);
    frame(8'h66);
    chk_out("bksp", 1'b1, 32'h0000_0008);
    frame(8'hF0); frame(8'h66);

    // Asynchronous reset while a key is held
    frame(8'h45);
    chk_out("held_0", 1'b1, 32'h0000_0030);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 chk_out("async_rst", 1'b0, 32'h0);
    chk("rst_addr", {19'h0, kif.key_ram_addr}, 32'h0000_0310);
    idle(4);
    reset_n = 1'b1;
    idle(20);
    frame(8'h1C);
    chk_out("post_rst", 1'b1, 32'h0000_0061);
    frame(8'hF0); frame(8'h1C);

    // Reset in the middle of a frame, then a clean frame decodes normally
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    reset_n = 1'b0;
    idle(4);
    reset_n = 1'b1;
    idle(50);
    frame(8'h2C);
    chk_out("midframe_rst", 1'b1, 32'h0000_0074);
    chk("final_addr", {19'h0, kif.key_ram_addr}, 32'h0000_0310);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_ram_writer.md
KEY_RAM_WRITER -- requirements
Module: key_ram_writer

Interface
REQ-001 Parameter SCAN_ASCII_ADDR, default 13'h0310, byte address of the keyboard ASCII location driven on key_ram_addr.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, idle clock cycles (1 ms at 50 MHz) after which a partial PS/2 frame is abandoned.
REQ-003 clock  input  1  system clock (50 MHz); the block has one clock, and all state is updated on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  PS/2 keyboard clock, asynchronous to clock.
REQ-006 ps2_data  input  1  PS/2 keyboard data, asynchronous to clock.
REQ-007 key_ram_addr  output  13  byte address of the key write port; always SCAN_ASCII_ADDR.
REQ-008 key_ram_wdata  output  32  {24'h0, ASCII} of the currently held key; 32'h0 when no key is held.
REQ-009 key_ram_wen  output  1  high while a mapped key is held; the RAM bypasses its read data to key_ram_wdata only while this is high.

Function
REQ-010 ps2_clk and ps2_data shall each pass through a 2-flop synchronizer; a falling edge is detected as synced-previous=1 and synced-current=0.
REQ-011 The frame receiver FSM shall have the states IDLE, DATA, PARITY and STOP, and it shall sample ps2_data only in the cycle a falling edge is detected.
REQ-012 IDLE: sampled 0 (start bit) -> DATA with bit count 0; sampled 1 -> stay in IDLE.
REQ-013 DATA: shift the bits in LSB first; after the 8th bit -> PARITY.
REQ-014 PARITY: store the bit -> STOP.
REQ-015 STOP: if stop=1 and the 9 bits (data+parity) have odd parity, pulse byte_valid for one cycle at T+1, where T is the stop-edge cycle; otherwise discard the byte; in both cases -> IDLE.
REQ-016 In any non-IDLE state, TIMEOUT_CYCLES consecutive cycles with no falling edge shall return the FSM to IDLE and discard the partial byte; the counter shall restart on every falling edge.
REQ-017 Decoder, byte E0: set the ext flag.
REQ-018 Decoder, byte F0: set the brk flag.
REQ-019 Decoder, any other byte: the byte is a key code and is processed with ext/brk; then ext and brk are cleared.
REQ-020 Shift handling: codes 12 and 59 without ext set the shift flag on make and clear it on break; they produce no output.
REQ-021 Key map (set 2, without ext), letters a-z: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
REQ-022 Letters are lowercase ASCII, or uppercase when shift is set.
REQ-023 Key map, digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'; shift has no effect on digits.
REQ-024 Key map, other keys: 29 -> 0x20, 5A -> 0x0D, 66 -> 0x08.
REQ-025 Make of a mapped code: at T+2 set key_ram_wen=1 and key_ram_wdata={24'h0, ASCII}, and record the code as held_code; this replaces any previously held key.
REQ-026 Typematic repeat (make of held_code while it is held) shall leave the outputs unchanged.
REQ-027 Break of held_code: at T+2 set key_ram_wen=0 and key_ram_wdata=32'h0, and clear held_code.
REQ-028 Break of any other code shall leave the outputs unchanged.
REQ-029 Unmapped codes and any code with ext set shall not change the outputs or held_code.
REQ-030 A byte arriving while the previous byte is still being decoded cannot occur (a PS/2 frame is ≥ 500 cycles long); no buffering is required.
REQ-031 key_ram_wen and key_ram_wdata shall be registered outputs, glitch-free, and change only together.

Reset
REQ-032 When reset_n=0: FSM=IDLE, bit and timeout counters=0, ext/brk/shift=0, held_code cleared, key_ram_wen=0, key_ram_wdata=32'h0, synchronizers=1.
REQ-033 key_ram_addr shall equal SCAN_ASCII_ADDR at all times, including during reset.
REQ-034 Asserting reset mid-frame or while a key is held shall take effect immediately; the first frame after release shall be decoded normally.

Verification
REQ-035 Frame 1C (parity 0, stop 1) -> key_ram_wen=1 and key_ram_wdata=32'h00000061 exactly 2 cycles after the stop edge.
REQ-036 Frames 12, 1C, F0 1C, F0 12 -> wdata=32'h00000041 while 1C is held; wen=0 and wdata=0 after F0 1C; shift=0 at the end.
REQ-037 Frame 1C with a wrong parity bit, then frame 1C with stop=0 -> wen stays 0 throughout.
REQ-038 Four data bits of a frame then 60000 idle cycles, then a valid frame 29 -> wen=1 and wdata=32'h00000020.
REQ-039 1C held, then make 32, then F0 1C -> wdata=32'h00000062 after 32, unchanged after F0 1C; then E0 75 and E0 F0 75 -> no change.
REQ-040 reset_n pulled low while 45 is held -> wen=0 and wdata=0 asynchronously, and key_ram_addr=13'h0310 throughout.
